// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bundle.
// master drives req/addr; slave returns ready, rvalid, rdata, err.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_err_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rvalid_i,
    input  imem_rdata_i,
    input  imem_err_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rvalid_i,
    output imem_rdata_i,
    output imem_err_i
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC, one-outstanding imem fetch, BTB predict (FETCH_BTB_EN), redirect.
// Ports: clk_i/rsn_i, stall/redirect/upd_* in, imem bus (if), fetch_* + stall_fetch_o out.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter int unsigned BTB_IDX_W = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk_i,
  input  logic         rsn_i,
  input  logic         stall_core_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  input  logic         upd_valid_i,
  input  logic [31:0]  upd_pc_i,
  input  logic [31:0]  upd_target_i,
  input  logic         upd_taken_i,
  fetch_unit_if.master imem,
  output logic [31:0]  fetch_instr_o,
  output logic [31:0]  fetch_pc_o,
  output logic [31:0]  fetch_pred_pc_o,
  output logic         fetch_prediction_o,
  output logic         fetch_taken_o,
  output logic         fetch_misaligned_instr_exc_o,
  output logic         fetch_instr_fault_exc_o,
  output logic         stall_fetch_o
);

  typedef enum logic [1:0] {
    S_FETCH, S_WAIT, S_HOLD, S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] lk_pc_q, lk_pc_d;
  logic [31:0] lk_pred_q, lk_pred_d;
  logic        lk_hit_q, lk_hit_d;
  logic        lk_tk_q, lk_tk_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] opred_q, opred_d;
  logic        opr_q, opr_d;
  logic        otk_q, otk_d;
  logic        mis_q, mis_d;
  logic        flt_q, flt_d;
  logic        stall_q, stall_d;

  logic        hit, tk;
  logic [31:0] pc_inc, pred;
  logic        aligned, issue;

  assign pc_inc  = pc_q + 32'd4;
  assign aligned = (pc_q[1:0] == 2'b00);
  // FETCH, or HOLD whose presented word is consumed this cycle
  assign issue   = (state_q == S_FETCH) ||
                   (state_q == S_HOLD && !stall_core_i);

`ifdef FETCH_BTB_EN
  localparam int unsigned N     = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W = 32 - BTB_IDX_W - 2;

  logic [N-1:0]         v_q;
  logic [TAG_W-1:0]     tag_q [N];
  logic [31:0]          tgt_q [N];
  logic [1:0]           ctr_q [N];
  logic [BTB_IDX_W-1:0] lidx, uidx;
  logic [TAG_W-1:0]     ltag, utag;
  logic                 uhit;
  logic                 unused_upd;

  assign lidx = pc_q[BTB_IDX_W+1:2];
  assign ltag = pc_q[31:BTB_IDX_W+2];
  assign uidx = upd_pc_i[BTB_IDX_W+1:2];
  assign utag = upd_pc_i[31:BTB_IDX_W+2];
  assign hit  = v_q[lidx] && (tag_q[lidx] == ltag);
  assign uhit = v_q[uidx] && (tag_q[uidx] == utag);
  assign tk   = hit && ctr_q[lidx][1];
  assign pred = tk ? tgt_q[lidx] : pc_inc;
  assign unused_upd = ^upd_pc_i[1:0];

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) v_q <= '0;
    else if (upd_valid_i && !uhit && upd_taken_i)
      v_q[uidx] <= 1'b1;
  end

  // payload is only meaningful behind a set valid bit
  always_ff @(posedge clk_i) begin
    if (upd_valid_i) begin
      if (uhit) begin
        if (upd_taken_i) begin
          if (ctr_q[uidx] != 2'b11)
            ctr_q[uidx] <= ctr_q[uidx] + 2'd1;
          tgt_q[uidx] <= upd_target_i;
        end else if (ctr_q[uidx] != 2'b00) begin
          ctr_q[uidx] <= ctr_q[uidx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        tag_q[uidx] <= utag;
        tgt_q[uidx] <= upd_target_i;
        ctr_q[uidx] <= 2'b10;
      end
    end
  end
`else
  localparam int unsigned unused_idx_w = BTB_IDX_W;
  logic unused_upd;

  assign hit  = 1'b0;
  assign tk   = 1'b0;
  assign pred = pc_inc;
  assign unused_upd = ^{upd_valid_i, upd_pc_i,
                        upd_target_i, upd_taken_i};
`endif

  // redirect gates the request so nothing is accepted on a kill
  assign imem.imem_req_o  = rsn_i && !redirect_i &&
                            issue && aligned;
  assign imem.imem_addr_o = pc_q;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      if (state_q == S_WAIT || state_q == S_DRAIN)
        state_d = imem.imem_rvalid_i ? S_FETCH : S_DRAIN;
      else
        state_d = S_FETCH;
    end else begin
      unique case (1'b1)
        issue: begin
          if (!aligned)               state_d = S_HOLD;
          else if (imem.imem_ready_i) state_d = S_WAIT;
          else                        state_d = S_FETCH;
        end
        (state_q == S_WAIT):
          if (imem.imem_rvalid_i) state_d = S_HOLD;
        (state_q == S_DRAIN):
          if (imem.imem_rvalid_i) state_d = S_FETCH;
        default: ;
      endcase
    end
  end

  always_comb begin
    pc_d      = pc_q;
    lk_pc_d   = lk_pc_q;
    lk_pred_d = lk_pred_q;
    lk_hit_d  = lk_hit_q;
    lk_tk_d   = lk_tk_q;
    instr_d   = instr_q;
    opc_d     = opc_q;
    opred_d   = opred_q;
    opr_d     = opr_q;
    otk_d     = otk_q;
    mis_d     = mis_q;
    flt_d     = flt_q;
    stall_d   = stall_q;
    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      instr_d = '0;
      opc_d   = '0;
      opred_d = '0;
      opr_d   = 1'b0;
      otk_d   = 1'b0;
      mis_d   = 1'b0;
      flt_d   = 1'b0;
      stall_d = 1'b1;
    end else begin
      unique case (1'b1)
        issue: begin
          if (!aligned) begin
            instr_d = NOP_INSTR;
            opc_d   = pc_q;
            opred_d = pc_inc;
            opr_d   = 1'b0;
            otk_d   = 1'b0;
            mis_d   = 1'b1;
            flt_d   = 1'b0;
            stall_d = 1'b0;
            pc_d    = pc_inc;
          end else begin
            stall_d = 1'b1;
            if (imem.imem_ready_i) begin
              lk_pc_d   = pc_q;
              lk_pred_d = pred;
              lk_hit_d  = hit;
              lk_tk_d   = tk;
              pc_d      = pred;
            end
          end
        end
        (state_q == S_WAIT): begin
          if (imem.imem_rvalid_i) begin
            instr_d = imem.imem_err_i ? NOP_INSTR
                                      : imem.imem_rdata_i;
            opc_d   = lk_pc_q;
            opred_d = lk_pred_q;
            opr_d   = lk_hit_q;
            otk_d   = lk_tk_q;
            mis_d   = 1'b0;
            flt_d   = imem.imem_err_i;
            stall_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      pc_q      <= RESET_PC;
      lk_pc_q   <= '0;
      lk_pred_q <= '0;
      lk_hit_q  <= 1'b0;
      lk_tk_q   <= 1'b0;
      instr_q   <= '0;
      opc_q     <= '0;
      opred_q   <= '0;
      opr_q     <= 1'b0;
      otk_q     <= 1'b0;
      mis_q     <= 1'b0;
      flt_q     <= 1'b0;
      stall_q   <= 1'b1;
    end else begin
      pc_q      <= pc_d;
      lk_pc_q   <= lk_pc_d;
      lk_pred_q <= lk_pred_d;
      lk_hit_q  <= lk_hit_d;
      lk_tk_q   <= lk_tk_d;
      instr_q   <= instr_d;
      opc_q     <= opc_d;
      opred_q   <= opred_d;
      opr_q     <= opr_d;
      otk_q     <= otk_d;
      mis_q     <= mis_d;
      flt_q     <= flt_d;
      stall_q   <= stall_d;
    end
  end

  assign fetch_instr_o                = instr_q;
  assign fetch_pc_o                   = opc_q;
  assign fetch_pred_pc_o              = opred_q;
  assign fetch_prediction_o           = opr_q;
  assign fetch_taken_o                = otk_q;
  assign fetch_misaligned_instr_exc_o = mis_q;
  assign fetch_instr_fault_exc_o      = flt_q;
  assign stall_fetch_o                = stall_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit.
// Memory responder, stream-level model of PC flow and BTB.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rsn;
  logic        stall_core;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] f_instr, f_pc, f_pred;
  logic        f_prd, f_tk, f_mis, f_flt, f_stall;

  fetch_unit_if mif ();

  fetch_unit dut (
    .clk_i                        (clk),
    .rsn_i                        (rsn),
    .stall_core_i                 (stall_core),
    .redirect_i                   (redirect),
    .redirect_pc_i                (redirect_pc),
    .upd_valid_i                  (upd_valid),
    .upd_pc_i                     (upd_pc),
    .upd_target_i                 (upd_target),
    .upd_taken_i                  (upd_taken),
    .imem                         (mif),
    .fetch_instr_o                (f_instr),
    .fetch_pc_o                   (f_pc),
    .fetch_pred_pc_o              (f_pred),
    .fetch_prediction_o           (f_prd),
    .fetch_taken_o                (f_tk),
    .fetch_misaligned_instr_exc_o (f_mis),
    .fetch_instr_fault_exc_o      (f_flt),
    .stall_fetch_o                (f_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;
  int n_present = 0;

  task automatic check32(string tag, logic [31:0] obs,
                         logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(string tag, logic obs, logic exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // memory contents and bus-error map
  function automatic logic [31:0] memf(logic [31:0] a);
    return ((a - 32'h1000) << 8) | 32'h93;
  endfunction

  function automatic logic errf(logic [31:0] a);
    return (a == 32'h1008) || (a[7:2] == 6'h2B);
  endfunction

  // BTB model: 16 slots, slot = word address mod 16
  typedef struct {
    bit          v;
    logic [31:0] pc;
    logic [31:0] tgt;
    int          ctr;
  } bte_t;
  bte_t btb [16];

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int i;
    i = m_idx(pc);
    return btb[i].v && ((btb[i].pc >> 6) == (pc >> 6));
  endfunction

  function automatic bit m_tk(logic [31:0] pc);
    return m_hit(pc) && (btb[m_idx(pc)].ctr >= 2);
  endfunction

  function automatic logic [31:0] m_pred(logic [31:0] pc);
    return m_tk(pc) ? btb[m_idx(pc)].tgt : pc + 32'd4;
  endfunction

  task automatic m_update(logic [31:0] pc, logic [31:0] t,
                          bit taken);
`ifdef FETCH_BTB_EN
    int i;
    i = m_idx(pc);
    if (m_hit(pc)) begin
      if (taken) begin
        if (btb[i].ctr < 3) btb[i].ctr++;
        btb[i].tgt = t;
      end else if (btb[i].ctr > 0) begin
        btb[i].ctr--;
      end
    end else if (taken) begin
      btb[i] = '{1'b1, pc, t, 2};
    end
`else
    if (pc === t && taken) btb[0].v = btb[0].v;
`endif
  endtask

  // memory responder knobs
  int lat_min = 0;
  int lat_max = 0;
  int ready_pct = 100;
  bit          pend;
  logic [31:0] paddr;
  int          cnt;

  initial begin
    mif.imem_ready_i  = 1'b0;
    mif.imem_rvalid_i = 1'b0;
    mif.imem_rdata_i  = '0;
    mif.imem_err_i    = 1'b0;
    pend = 1'b0;
    paddr = '0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      mif.imem_ready_i  = 1'b0;
      mif.imem_rvalid_i = 1'b0;
      mif.imem_rdata_i  = '0;
      mif.imem_err_i    = 1'b0;
      if (!rsn) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          mif.imem_rvalid_i = 1'b1;
          mif.imem_rdata_i  = memf(paddr);
          mif.imem_err_i    = errf(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end else if (mif.imem_req_o &&
                   $urandom_range(0, 99) < ready_pct) begin
        mif.imem_ready_i = 1'b1;
        pend  = 1'b1;
        paddr = mif.imem_addr_o;
        cnt   = $urandom_range(lat_max, lat_min);
      end
    end
  end

  // stream monitor: every presented word follows the model PC
  bit          chk_en = 1'b0;
  bit          newp = 1'b0;
  bit          held = 1'b0;
  logic [31:0] m_pc = '0;
  logic [100:0] snap, cur;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cur = {f_pc, f_instr, f_pred, f_prd, f_tk,
               f_mis, f_flt, f_stall};
        if (held) check1("hold_stable", cur == snap, 1'b1);
        if (newp && !f_stall) begin
          n_present++;
          check32("s_pc", f_pc, m_pc);
          check32("s_instr", f_instr,
                  errf(m_pc) ? NOP : memf(m_pc));
          check1("s_fault", f_flt, errf(m_pc));
          check1("s_mis", f_mis, 1'b0);
          check1("s_prd", f_prd, m_hit(m_pc));
          check1("s_tk", f_tk, m_tk(m_pc));
          check32("s_pred", f_pred, m_pred(m_pc));
          m_pc = m_pred(m_pc);
          newp = 1'b0;
        end
        snap = cur;
        held = !f_stall && stall_core && !redirect;
        if (f_stall || !stall_core) newp = 1'b1;
        if (redirect) begin
          m_pc = redirect_pc;
          newp = 1'b1;
        end
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic upd(logic [31:0] pc, logic [31:0] t, bit taken);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = t;
    upd_taken  = taken;
    m_update(pc, t, taken);
    adv();
    upd_valid = 1'b0;
  endtask

  task automatic btb_probe(string tag);
    redirect    = 1'b1;
    redirect_pc = 32'h1010;
    adv();
    redirect = 1'b0;
    settle();
    check32({tag, "_addr"}, mif.imem_addr_o, 32'h1010);
    adv();
    adv();
    settle();
    check1({tag, "_prd"}, f_prd, m_hit(32'h1010));
    check1({tag, "_tk"}, f_tk, m_tk(32'h1010));
    check32({tag, "_pred"}, f_pred, m_pred(32'h1010));
    check32({tag, "_next"}, mif.imem_addr_o, m_pred(32'h1010));
  endtask

  initial begin
    rsn = 1'b0;
    stall_core = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_target = '0;
    upd_taken = 1'b0;
    for (int i = 0; i < 16; i++) btb[i] = '{1'b0, '0, '0, 0};

    adv();
    adv();
    settle();
    check1("rst_req", mif.imem_req_o, 1'b0);
    check1("rst_stall", f_stall, 1'b1);
    check32("rst_instr", f_instr, 32'h0);
    check32("rst_pc", f_pc, 32'h0);

    adv();
    rsn = 1'b1;
    settle();
    check1("first_req", mif.imem_req_o, 1'b1);
    check32("first_addr", mif.imem_addr_o, 32'h1000);
    adv();
    adv();
    settle();
    check32("p0_pc", f_pc, 32'h1000);
    check32("p0_instr", f_instr, 32'h93);
    check32("p0_pred", f_pred, 32'h1004);
    check1("p0_stall", f_stall, 1'b0);
    check32("p0_next", mif.imem_addr_o, 32'h1004);
    adv();
    settle();
    check1("wait_stall", f_stall, 1'b1);

    adv();
    stall_core = 1'b1;
    settle();
    for (int k = 0; k < 4; k++) begin
      check32("hs_pc", f_pc, 32'h1004);
      check32("hs_instr", f_instr, memf(32'h1004));
      check32("hs_pred", f_pred, 32'h1008);
      check1("hs_stall", f_stall, 1'b0);
      check1("hs_req", mif.imem_req_o, 1'b0);
      check32("hs_addr", mif.imem_addr_o, 32'h1008);
      if (k < 3) begin
        adv();
        settle();
      end
    end
    adv();
    stall_core = 1'b0;
    settle();
    check1("rel_req", mif.imem_req_o, 1'b1);
    adv();
    adv();
    lat_min = 1;
    lat_max = 1;
    settle();
    check32("err_pc", f_pc, 32'h1008);
    check1("err_fault", f_flt, 1'b1);
    check32("err_instr", f_instr, NOP);

    adv();
    redirect = 1'b1;
    redirect_pc = 32'h2000;
    settle();
    check1("rd_req", mif.imem_req_o, 1'b0);
    adv();
    redirect = 1'b0;
    settle();
    check1("drain_req", mif.imem_req_o, 1'b0);
    check1("drain_stall", f_stall, 1'b1);
    check32("drain_instr", f_instr, 32'h0);
    adv();
    lat_min = 0;
    lat_max = 0;
    settle();
    check1("rd_fetch_req", mif.imem_req_o, 1'b1);
    check32("rd_fetch_addr", mif.imem_addr_o, 32'h2000);
    adv();
    adv();
    redirect = 1'b1;
    redirect_pc = 32'h2002;
    settle();
    check32("rd_pc", f_pc, 32'h2000);
    check32("rd_instr", f_instr, memf(32'h2000));
    check1("rd_stall", f_stall, 1'b0);

    adv();
    redirect = 1'b0;
    settle();
    check1("mis_noreq", mif.imem_req_o, 1'b0);
    adv();
    settle();
    check32("mis_instr", f_instr, NOP);
    check1("mis_flag", f_mis, 1'b1);
    check32("mis_pc", f_pc, 32'h2002);
    check32("mis_pred", f_pred, 32'h2006);
    check1("mis_prd", f_prd, 1'b0);
    check1("mis_stall", f_stall, 1'b0);

    adv();
    upd(32'h1010, 32'h1100, 1'b1);
    btb_probe("btb_t");
    adv();
    upd(32'h1010, 32'h1200, 1'b0);
    upd(32'h1010, 32'h1200, 1'b0);
    btb_probe("btb_nt");

    for (int k = 0; k < 12; k++) begin
      upd(32'h1000 + 4 * $urandom_range(0, 63),
          32'h1000 + 4 * $urandom_range(0, 63),
          1'($urandom_range(0, 1)));
    end

    ready_pct = 60;
    lat_min = 0;
    lat_max = 2;
    chk_en = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h1000;
    adv();
    for (int c = 0; c < 1500; c++) begin
      stall_core = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 3);
      redirect_pc = 32'h1000 + 4 * $urandom_range(0, 63);
      adv();
    end
    redirect = 1'b0;
    stall_core = 1'b0;
    adv();
    adv();
    chk_en = 1'b0;
    check1("present_cnt", n_present > 30, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Front-end fetch stage that produces the fetch-side inputs of the fetch/decode pipeline latch. It owns the PC register and issues one instruction-memory request at a time. It looks up a small direct-mapped BTB with 2-bit counters to form the predicted next PC. It also flags misaligned and fault exceptions, and handles redirects (kill) from later stages.

Parameters:
RESET_PC, 32'h0000_1000, PC loaded on reset
BTB_IDX_W, 4, BTB index width; 2**BTB_IDX_W entries, indexed by pc[BTB_IDX_W+1:2], tag = pc[31:BTB_IDX_W+2]
NOP_INSTR, 32'h0000_0013, instruction word emitted with an exception

Ports:
clk_i  in  1  clock
rsn_i  in  1  reset, asynchronous, active-low
stall_core_i  in  1  downstream stall; hold presented instruction
redirect_i  in  1  kill/redirect from execute
redirect_pc_i  in  32  redirect target
upd_valid_i  in  1  BTB update strobe from execute
upd_pc_i  in  32  PC of resolved branch
upd_target_i  in  32  resolved target
upd_taken_i  in  1  resolved direction
imem_req_o  out  1  memory request valid
imem_addr_o  out  32  request address (= pc)
imem_ready_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid
imem_rdata_i  in  32  response instruction
imem_err_i  in  1  response bus error, qualified by rvalid
fetch_instr_o  out  32  instruction
fetch_pc_o  out  32  instruction PC
fetch_pred_pc_o  out  32  predicted next PC
fetch_prediction_o  out  1  BTB hit (prediction made)
fetch_taken_o  out  1  predicted taken
fetch_misaligned_instr_exc_o  out  1  pc[1:0] != 0
fetch_instr_fault_exc_o  out  1  imem_err_i on response
stall_fetch_o  out  1  no valid instruction presented this cycle (latch inserts bubble)

Behaviour:
- Reset (async assert): pc=RESET_PC, state FETCH, imem_req_o=0, all fetch_* outputs 0, stall_fetch_o=1, all BTB valid bits 0. A response arriving during or after reset while not in WAIT is ignored.
- States: FETCH, WAIT, HOLD, DRAIN. At most one request outstanding.
- FETCH: if pc[1:0]!=0, no request. Next cycle present NOP_INSTR with misaligned=1, pred_pc=pc+4, prediction=0, taken=0, then go HOLD. Otherwise drive imem_req_o=1, imem_addr_o=pc and latch the BTB lookup result. On imem_ready_i go WAIT and set pc<=pred_pc. Without ready, hold request and address stable.
- Prediction: hit = valid & tag match. taken = hit & ctr[1]. pred_pc = taken ? target : pc+4 (32-bit wrap).
- WAIT: on imem_rvalid_i, register outputs: instr = err ? NOP_INSTR : rdata, fault = err, pc/pred/prediction/taken from the latched lookup, stall_fetch_o=0. Outputs are valid the cycle after rvalid. Go HOLD.
- HOLD: outputs presented. If stall_core_i=0, the latch consumes them this cycle; the next request issues in the same cycle (FETCH behaviour merged) and stall_fetch_o=1 from the following cycle until the next response. If stall_core_i=1, all outputs hold stable.
- Throughput: one instruction per 2 cycles minimum with a 1-cycle memory.
- redirect_i (highest priority, any state): pc<=redirect_pc_i, stall_fetch_o=1 and fetch_* outputs zeroed next cycle. If a request is outstanding and rvalid is not seen in the same cycle, go DRAIN; otherwise go FETCH. A same-cycle rvalid is discarded.
- DRAIN: imem_req_o=0. Drop the next rvalid, then go FETCH. Another redirect_i in DRAIN only updates pc.
- BTB update (edge of upd_valid_i cycle): on tag hit, ctr saturating ++ if taken else --, and target<=upd_target_i if taken. On miss with taken: allocate, tag set, target, ctr=2'b10, valid=1. On miss with not-taken: no change.
- A lookup in the same cycle as an update to the same index sees the old contents.

Optional Feature:
FETCH_BTB_EN: defined -> BTB present as above. Undefined -> no BTB storage; pred_pc=pc+4, prediction=0, taken=0 always; upd_* ports ignored.

Test Plan:
- Reset release, 1-cycle memory returning 32'h0000_0093 -> imem_addr_o=0x1000 first; outputs pc=0x1000, instr=0x93, pred=0x1004, stall_fetch_o=0; next addr 0x1004.
- stall_core_i held 3 cycles in HOLD -> all fetch_* outputs stable, imem_req_o=0, no pc advance.
- redirect_i to 0x2000 while WAIT, rvalid arrives one cycle later -> response dropped, next request addr 0x2000, no instruction presented from the old pc.
- redirect_pc_i=0x2002 -> no request; instr=0x13, misaligned=1, pc=0x2002.
- rvalid with imem_err_i=1 at pc 0x1008 -> fault=1, instr=0x13.
- (FETCH_BTB_EN) update pc 0x1010 taken target 0x1100, then fetch 0x1010 -> prediction=1, taken=1, pred=0x1100, next addr 0x1100. After two not-taken updates -> taken=0, pred=0x1014.
